axi3_rd_slave: RTL and testbench
================================

AXI3_RD_SLAVE -- requirements
Module: axi3_rd_slave

Interface
- REQ-001 Parameters SHALL be as follows.
  - DATA_WIDTH, default 32, data beat width in bits.
  - ID_WIDTH, default 4, arid/rid width.
  - MEM_AW, default 12, word-address width of the backing RAM.
  - BASE_ADDR, default 32'h1fc0_0000, region base; aligned to 2^(MEM_AW+2) bytes.
  - RD_LATENCY, default 2, extra wait cycles before the first beat (0..15).
- REQ-002 Clocking: one clock; reset is synchronous and active-high.
- REQ-003 Ports SHALL be as follows (name, direction, width, meaning).
  - clk, in, 1: clock.
  - rst, in, 1: synchronous active-high reset.
  - arid, in, ID_WIDTH: read ID.
  - araddr, in, 32: byte address.
  - arlen, in, 4: beats minus 1.
  - arsize, in, 3: log2 bytes per beat.
  - arburst, in, 2: 00 FIXED, 01 INCR, 10 WRAP.
  - arvalid, in, 1: AR valid.
  - arready, out, 1: AR accept.
  - rid, out, ID_WIDTH: response ID.
  - rdata, out, DATA_WIDTH: read data.
  - rresp, out, 2: 00 OKAY, 10 SLVERR, 11 DECERR.
  - rlast, out, 1: final beat.
  - rvalid, out, 1: R valid.
  - rready, in, 1: R accept.
  - mem_en, out, 1: RAM read enable.
  - mem_addr, out, MEM_AW: RAM word address.
  - mem_rdata, in, DATA_WIDTH: RAM data, valid the cycle after mem_en.

Function
- REQ-004 FSM states SHALL be IDLE, WAIT, BURST; only one outstanding burst; no reordering.
- REQ-005 arready SHALL be 1 only in IDLE; an AR handshake (arvalid&arready at an edge E0) SHALL latch arid, araddr, arlen, arsize and arburst, and move the FSM to WAIT.
- REQ-006 WAIT SHALL count RD_LATENCY cycles, then enter BURST; with RD_LATENCY=0, WAIT SHALL last zero cycles.
- REQ-007 The first rvalid SHALL be high after edge E0+RD_LATENCY+1.
- REQ-008 rid SHALL equal the latched arid for every beat.
- REQ-009 Once rvalid=1, rdata/rresp/rlast/rid SHALL hold stable until rvalid&rready.
- REQ-010 With rready held at 1, beats SHALL issue back-to-back, one per cycle, with no bubbles.
- REQ-011 Under rready=0 backpressure, no beat SHALL be lost or duplicated; the block SHALL use a 2-entry output skid buffer, or stall mem_en.
- REQ-012 Beat count SHALL be arlen+1; rlast=1 exactly on beat arlen.
- REQ-013 On the rlast handshake the FSM SHALL return to IDLE, with arready=1 the next cycle.
- REQ-014 Address stepping SHALL use a byte step of 2^arsize.
  - INCR: addr += step.
  - FIXED: addr constant.
  - WRAP: wrap boundary = (arlen+1)*step; the address wraps to the aligned base of that window.
- REQ-015 WRAP with arlen not in {1,3,7,15} SHALL be treated as INCR.
- REQ-016 mem_addr SHALL be the current beat byte address [MEM_AW+1:2].
- REQ-017 rresp DECERR (rdata=0) SHALL apply to a beat whose address bits [31:MEM_AW+2] differ from those of BASE_ADDR; an INCR burst crossing the region end SHALL error only the out-of-range beats.
- REQ-018 rresp SLVERR (rdata=0) SHALL apply to all beats when arsize > log2(DATA_WIDTH/8) or arburst=11.
- REQ-019 All other beats SHALL return mem_rdata with rresp OKAY.
- REQ-020 mem_en SHALL be 1 only for in-range, non-error beats; it SHALL be 0 in IDLE and 0 in WAIT, except during WAIT's final cycle, when it prefetches beat 0.
- REQ-021 A new arvalid while busy SHALL be held off (arready=0) and accepted in IDLE.

Reset
- REQ-022 While rst=1 at an edge, the FSM SHALL go to IDLE, beat and wait counters SHALL go to 0, and the skid buffer SHALL empty.
- REQ-023 Output reset values: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_en=0.
- REQ-024 arready SHALL rise the first cycle after rst deasserts.
- REQ-025 Reset mid-burst SHALL abort the burst: rvalid=0 after the reset edge; no further beats of the aborted burst SHALL appear.

Verification
- REQ-026 V1 INCR: araddr=BASE+0x10, arlen=3, arsize=2, RD_LATENCY=2, rready=1 -> 4 beats RAM[4..7]; first rvalid 3 edges after handshake; rlast on beat 3; all OKAY.
- REQ-027 V2 WRAP: araddr=BASE+0x14, arlen=7, arsize=2 -> word order 5,6,7,0,1,2,3,4; rlast on word 4.
- REQ-028 V3 backpressure: V1 with rready toggling 1,0,0,1,0,1... -> same 4 beats in order; data stable while rready=0; no duplicates.
- REQ-029 V4 errors, each -> all beats with the stated response and rdata=0:
  - araddr=BASE+2^(MEM_AW+2): 2 beats, DECERR.
  - arsize=3: SLVERR.
  - arburst=11: SLVERR.
- REQ-030 V5 reset mid-burst: rst=1 for one cycle during beat 2 of arlen=7 -> rvalid=0 next cycle; arready=1 one cycle after rst drops; next burst arid=5 returns rid=5 correct data.
- REQ-031 V6 back-to-back ARs: arvalid held with 2 requests -> second accepted the cycle after first rlast handshake; no overlap of R beats.

Source files
------------

// File: rtl/axi3_rd_slave.sv
// AXI3 read-only slave in front of a synchronous single-port RAM.
// Serves one burst at a time: an AR is latched, an optional wait phase
// elapses, then beats are fetched from RAM and returned on R through a
// 2-entry skid buffer. Decode and size/burst errors produce zero data.
module axi3_rd_slave #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter int          MEM_AW     = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h1fc0_0000,
  parameter int          RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [31:0]           araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int         LOG2_BPB = $clog2(DATA_WIDTH/8);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  state_t              r_state;
  logic                r_arready;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_addr;
  logic [3:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_slverr;
  logic [3:0]          r_wcnt;
  logic [3:0]          r_beat;
  logic                r_idone;
  // beat issued to RAM last cycle; its data is on mem_rdata now
  logic                r_ret_vld;
  logic [1:0]          r_ret_resp;
  logic                r_ret_last;
  beat_t               r_q [2];
  logic [1:0]          r_q_cnt;

  logic        w_go, w_issue, w_room, w_last_issue, w_decerr;
  logic [1:0]  w_resp;
  logic [31:0] w_step, w_incr, w_wmask, w_wrap, w_next_addr;
  beat_t       w_ret, w_head;
  logic        w_hs, w_pop, w_take, w_push;
  logic [1:0]  w_base, w_next_cnt;

  // The beat-0 prefetch happens in the last wait cycle, so the first beat
  // is presented RD_LATENCY+1 edges after the AR handshake.
  assign w_go = (r_state == S_BURST) ||
                (r_state == S_WAIT && r_wcnt == 4'(RD_LATENCY));

  assign w_decerr     = r_addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2];
  assign w_resp       = r_slverr ? SLVERR : (w_decerr ? DECERR : OKAY);
  assign w_last_issue = (r_beat == r_len);
  assign w_issue      = w_go && !r_idone && w_room;
  assign mem_en       = w_issue && (w_resp == OKAY);
  assign mem_addr     = r_addr[MEM_AW+1:2];

  // Next beat address: wrap keeps the high part of the aligned window
  assign w_step  = 32'd1 << r_size;
  assign w_incr  = r_addr + w_step;
  assign w_wmask = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
  assign w_wrap  = (r_addr & ~w_wmask) | (w_incr & w_wmask);
  assign w_next_addr = (r_burst == 2'b00) ? r_addr :
                       (r_burst == 2'b10) ? w_wrap : w_incr;

  // Output head: oldest skid entry, else the beat returning from RAM
  always_comb begin
    w_ret      = '0;
    w_ret.data = (r_ret_resp == OKAY) ? mem_rdata : '0;
    w_ret.resp = r_ret_resp;
    w_ret.last = r_ret_last;
    w_head     = '0;
    if (r_q_cnt != 2'd0) w_head = r_q[0];
    else if (r_ret_vld)  w_head = w_ret;
  end

  assign rvalid  = (r_q_cnt != 2'd0) || r_ret_vld;
  assign rdata   = w_head.data;
  assign rresp   = w_head.resp;
  assign rlast   = w_head.last;
  assign rid     = r_id;
  assign arready = r_arready;

  assign w_hs   = rvalid && rready;
  assign w_pop  = w_hs && (r_q_cnt != 2'd0);
  assign w_take = w_hs && (r_q_cnt == 2'd0);
  assign w_push = r_ret_vld && !w_take;
  assign w_base = r_q_cnt - {1'b0, w_pop};
  assign w_next_cnt = w_base + {1'b0, w_push};
  // A beat fetched now lands next cycle; guarantee a free slot for it
  assign w_room = (w_next_cnt <= 2'd1);

  // Control FSM, AR capture and beat issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_arready  <= 1'b0;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_slverr   <= 1'b0;
      r_wcnt     <= '0;
      r_beat     <= '0;
      r_idone    <= 1'b0;
      r_ret_vld  <= 1'b0;
      r_ret_resp <= '0;
      r_ret_last <= 1'b0;
    end else begin
      r_ret_vld  <= w_issue;
      r_ret_resp <= w_resp;
      r_ret_last <= w_last_issue;
      if (w_issue) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + 4'd1;
        if (w_last_issue) r_idone <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            // WRAP with an illegal length degrades to INCR
            r_burst   <= (arburst == 2'b10 && !(arlen == 4'd1 || arlen == 4'd3 ||
                          arlen == 4'd7 || arlen == 4'd15)) ? 2'b01 : arburst;
            r_slverr  <= (arsize > 3'(LOG2_BPB)) || (arburst == 2'b11);
            r_beat    <= '0;
            r_idone   <= 1'b0;
            r_wcnt    <= '0;
            r_state   <= (RD_LATENCY == 0) ? S_BURST : S_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wcnt == 4'(RD_LATENCY)) r_state <= S_BURST;
          else                          r_wcnt  <= r_wcnt + 4'd1;
        end
        S_BURST: begin
          if (w_hs && w_head.last) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // 2-entry skid buffer absorbing returned beats under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_cnt <= '0;
      r_q[0]  <= '0;
      r_q[1]  <= '0;
    end else begin
      if (w_pop)  r_q[0] <= r_q[1];
      if (w_push) r_q[w_base[0]] <= w_ret;
      r_q_cnt <= w_next_cnt;
    end
  end

endmodule

// File: tb/tb_axi3_rd_slave.sv
// Directed + randomized bench for axi3_rd_slave with a RAM model and an
// address-list reference model computed from the burst rules.
module tb_axi3_rd_slave;
  localparam int          DW   = 32;
  localparam int          IW   = 4;
  localparam int          AW   = 12;
  localparam int          L    = 2;
  localparam logic [31:0] BASE = 32'h1fc0_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] arid;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  axi3_rd_slave #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(AW),
                  .BASE_ADDR(BASE), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  logic [31:0] ram [0:(1<<AW)-1];
  // Synchronous RAM; garbage when not enabled so un-requested data shows up
  always @(posedge clk) mem_rdata <= mem_en ? ram[mem_addr] : $urandom;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] e_data[$];
  logic [1:0]  e_resp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference: list of beat addresses, then response/data per beat
  task automatic build_exp(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst);
    logic [31:0] step, wb, lo, a;
    bit slv, wrap_ok;
    e_data.delete(); e_resp.delete();
    step    = 32'd1 << size;
    wb      = (len + 1) * step;
    lo      = addr - (addr % wb);
    slv     = (size > 2) || (burst == 2'b11);
    wrap_ok = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
    for (int i = 0; i <= len; i++) begin
      if (burst == 2'b00) a = addr;
      else if (wrap_ok)   a = lo + ((addr - lo) + i * step) % wb;
      else                a = addr + i * step;
      if (slv) begin
        e_data.push_back(0); e_resp.push_back(2'b10);
      end else if ((a >> (AW+2)) != (BASE >> (AW+2))) begin
        e_data.push_back(0); e_resp.push_back(2'b11);
      end else begin
        e_data.push_back(ram[(a >> 2) % (1<<AW)]); e_resp.push_back(2'b00);
      end
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst, input bit hold);
    int t = 0;
    @(negedge clk);
    arvalid = 1; arid = id; araddr = addr; arlen = 4'(len);
    arsize = 3'(size); arburst = burst;
    while (!arready && t < 60) begin @(negedge clk); t++; end
    if (!arready) chk("ar_accept", {63'd0, arready}, 64'd1);
    @(posedge clk); #1;
    if (!hold) arvalid = 0;
  endtask

  // Collect beats; mode 0: rready=1, 1: 1,0,0,1,0,1 pattern, 2: random
  task automatic collect(input logic [3:0] id, input int mode, input bit busy_ar);
    int k = 0, cyc = 0, p = 0, n;
    bit seen = 0, held = 0, ar_ok = 1;
    logic [38:0] hv;
    logic [5:0] pat = 6'b101001;
    n = e_data.size();
    while (k < n && cyc < 300) begin
      @(negedge clk); cyc++;
      if (rvalid && !seen) begin seen = 1; chk("first_rvalid_cycle", cyc, L + 2); end
      if (held) begin
        chk("hold_valid", {63'd0, rvalid}, 64'd1);
        chk("hold_stable", {rid, rdata, rresp, rlast}, hv);
      end
      if (busy_ar && arready) ar_ok = 0;
      if (mode == 0)      rready = 1;
      else if (mode == 1) begin rready = pat[p % 6]; if (rvalid) p++; end
      else                rready = 1'($urandom_range(0, 1));
      held = 0;
      if (rvalid && rready) begin
        chk("rid",   rid,   id);
        chk("rdata", rdata, e_data[k]);
        chk("rresp", rresp, e_resp[k]);
        chk("rlast", {63'd0, rlast}, {63'd0, k == n - 1});
        k++;
      end else if (rvalid) begin
        held = 1; hv = {rid, rdata, rresp, rlast};
      end
    end
    if (k < n) chk("beats_received", k, n);
    if (busy_ar) chk("ar_held_off", {63'd0, ar_ok}, 64'd1);
    @(negedge clk);
    chk("no_extra_beat", {63'd0, rvalid}, 64'd0);
    chk("arready_after_last", {63'd0, arready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, t;
    for (int i = 0; i < (1<<AW); i++) ram[i] = $urandom;
    rst = 1; arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
    arburst = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
    chk("rst_rlast",   {63'd0, rlast},   64'd0);
    chk("rst_rresp",   rresp, 0);
    chk("rst_rid",     rid,   0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_mem_en",  {63'd0, mem_en},  64'd0);
    rst = 0;
    @(negedge clk);
    chk("arready_after_reset", {63'd0, arready}, 64'd1);

    // V1 INCR
    build_exp(BASE + 32'h10, 3, 2, 2'b01);
    send_ar(4'd1, BASE + 32'h10, 3, 2, 2'b01, 0); collect(4'd1, 0, 0);
    // V2 WRAP 5,6,7,0..4
    build_exp(BASE + 32'h14, 7, 2, 2'b10);
    send_ar(4'd2, BASE + 32'h14, 7, 2, 2'b10, 0); collect(4'd2, 0, 0);
    // V3 backpressure
    build_exp(BASE + 32'h10, 3, 2, 2'b01);
    send_ar(4'd3, BASE + 32'h10, 3, 2, 2'b01, 0); collect(4'd3, 1, 0);
    // V4 errors
    build_exp(BASE + 32'h4000, 1, 2, 2'b01);
    send_ar(4'd4, BASE + 32'h4000, 1, 2, 2'b01, 0); collect(4'd4, 0, 0);
    build_exp(BASE + 32'h20, 3, 3, 2'b01);
    send_ar(4'd6, BASE + 32'h20, 3, 3, 2'b01, 0); collect(4'd6, 0, 0);
    build_exp(BASE + 32'h20, 3, 2, 2'b11);
    send_ar(4'd7, BASE + 32'h20, 3, 2, 2'b11, 0); collect(4'd7, 0, 0);
    // INCR crossing region end: last two beats DECERR
    build_exp(BASE + 32'h3ff8, 3, 2, 2'b01);
    send_ar(4'd8, BASE + 32'h3ff8, 3, 2, 2'b01, 0); collect(4'd8, 1, 0);
    // FIXED, and WRAP with illegal length treated as INCR
    build_exp(BASE + 32'h100, 4, 2, 2'b00);
    send_ar(4'd9, BASE + 32'h100, 4, 2, 2'b00, 0); collect(4'd9, 2, 0);
    build_exp(BASE + 32'h1c, 2, 2, 2'b10);
    send_ar(4'd10, BASE + 32'h1c, 2, 2, 2'b10, 0); collect(4'd10, 0, 0);

    // V5 reset during beat 2 of an 8-beat burst
    build_exp(BASE + 32'h40, 7, 2, 2'b01);
    send_ar(4'd2, BASE + 32'h40, 7, 2, 2'b01, 0);
    rready = 1; k = 0; t = 0;
    while (t < 100) begin
      @(negedge clk); t++;
      if (rvalid) begin
        if (k == 2) break;
        chk("v5_pre_beat", rdata, e_data[k]);
        k++;
      end
    end
    chk("v5_reached_beat2", k, 2);
    rst = 1;
    @(negedge clk);
    chk("v5_rvalid_after_rst", {63'd0, rvalid}, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("v5_arready_after_rst", {63'd0, arready}, 64'd1);
    chk("v5_no_stale_beat", {63'd0, rvalid}, 64'd0);
    build_exp(BASE + 32'h80, 3, 2, 2'b01);
    send_ar(4'd5, BASE + 32'h80, 3, 2, 2'b01, 0); collect(4'd5, 0, 0);

    // V6 two ARs with arvalid held throughout
    build_exp(BASE + 32'h200, 3, 2, 2'b01);
    send_ar(4'd11, BASE + 32'h200, 3, 2, 2'b01, 1);
    arid = 4'd12; araddr = BASE + 32'h300; arlen = 4'd2; arsize = 3'd2; arburst = 2'b01;
    collect(4'd11, 0, 1);
    @(posedge clk); #1; arvalid = 0;
    build_exp(BASE + 32'h300, 2, 2, 2'b01);
    collect(4'd12, 0, 0);

    // Randomized bursts
    for (int r = 0; r < 16; r++) begin
      logic [3:0] id; logic [1:0] bt; logic [31:0] a; int sz, ln;
      id = 4'($urandom); bt = 2'($urandom_range(0, 2));
      sz = $urandom_range(0, 2); ln = $urandom_range(0, 15);
      a  = BASE + ($urandom_range(0, (1<<AW) - 1) << 2);
      if (r % 5 == 4) a = BASE + 32'h3fe0 + ($urandom_range(0, 7) << 2);
      build_exp(a, ln, sz, bt);
      send_ar(id, a, ln, sz, bt, 0);
      collect(id, 2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
